// File: rtl/mandel_frame_timer.sv
// Frame render timer: counts prescaled ticks from a start pulse until every
// solver engine has produced a rising done edge, then latches the result.
module mandel_frame_timer #(
    parameter int NUM_SOLVERS = 4,
    parameter int CNT_WIDTH   = 32,
    parameter int PRESCALE    = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [NUM_SOLVERS-1:0] solver_done,
    output logic [CNT_WIDTH-1:0]   elapsed,
    output logic [CNT_WIDTH-1:0]   live_count,
    output logic                   busy,
    output logic                   valid,
    output logic                   overflow
);

    // state | meaning
    // IDLE  | no measurement; counter cleared, result registers hold
    // RUN   | counting ticks, collecting solver done edges
    // DONE  | frame finished; elapsed/live_count/overflow hold

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int                PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]     PS_LAST = PW'(PRESCALE - 1);

    state_t                 state_q, state_d;
    logic [PW-1:0]          presc_q;
    logic [CNT_WIDTH-1:0]   count_q;
    logic [CNT_WIDTH-1:0]   elapsed_q;
    logic [NUM_SOLVERS-1:0] seen_q;
    logic [NUM_SOLVERS-1:0] hist_q;
    logic                   valid_q;
    logic                   ovf_q;

    logic                   tick;
    logic                   at_max;
    logic                   sat_event;
    logic [CNT_WIDTH-1:0]   count_run;
    logic [NUM_SOLVERS-1:0] rise;
    logic [NUM_SOLVERS-1:0] seen_run;
    logic                   all_seen;
    logic                   complete;

    always_comb begin
        tick      = (presc_q == PS_LAST);
        at_max    = &count_q;
        // top bits all ones means this tick lands on (or is blocked at) the max value
        sat_event = tick && (&count_q[CNT_WIDTH-1:1]);
        count_run = count_q;
        if (tick && !at_max) begin
            count_run = count_q + CNT_WIDTH'(1);
        end
        rise      = solver_done & ~hist_q;
        seen_run  = seen_q | rise;
        all_seen  = &seen_run;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        complete = 1'b0;
        if (abort) begin
            state_d = IDLE;
        end else if (start) begin
            state_d = RUN;
        end else if (state_q == RUN && all_seen) begin
            state_d  = DONE;
            complete = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q   <= '0;
            count_q   <= '0;
            elapsed_q <= '0;
            seen_q    <= '0;
            hist_q    <= '0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            // history tracks in every state so a solver high across start needs a fresh edge
            hist_q <= solver_done;
            if (abort) begin
                presc_q <= '0;
                count_q <= '0;
                seen_q  <= '0;
            end else if (start) begin
                presc_q <= '0;
                count_q <= '0;
                seen_q  <= '0;
                ovf_q   <= 1'b0;
            end else if (state_q == RUN) begin
                presc_q <= tick ? '0 : presc_q + PW'(1);
                count_q <= count_run;
                seen_q  <= seen_run;
                if (sat_event) begin
                    ovf_q <= 1'b1;
                end
                if (complete) begin
                    elapsed_q <= count_run;
                    valid_q   <= 1'b1;
                end
            end
        end
    end

    assign elapsed    = elapsed_q;
    assign live_count = count_q;
    assign busy       = (state_q == RUN);
    assign valid      = valid_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_mandel_frame_timer.sv
// Self-checking bench: three timer configurations share stimulus; the default
// instance's run endings are checked through a scoreboard.
module tb_mandel_frame_timer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] solver_done = 4'b0;

    logic [31:0] elapsed_a, live_a;
    logic        busy_a, valid_a, ovf_a;
    logic [7:0]  elapsed_b, live_b;
    logic        busy_b, valid_b, ovf_b;
    logic [15:0] elapsed_c, live_c;
    logic        busy_c, valid_c, ovf_c;

    mandel_frame_timer #(.NUM_SOLVERS(4), .CNT_WIDTH(32), .PRESCALE(1)) u_a (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .solver_done(solver_done), .elapsed(elapsed_a), .live_count(live_a),
        .busy(busy_a), .valid(valid_a), .overflow(ovf_a));

    mandel_frame_timer #(.NUM_SOLVERS(4), .CNT_WIDTH(8), .PRESCALE(1)) u_b (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .solver_done(solver_done), .elapsed(elapsed_b), .live_count(live_b),
        .busy(busy_b), .valid(valid_b), .overflow(ovf_b));

    mandel_frame_timer #(.NUM_SOLVERS(4), .CNT_WIDTH(16), .PRESCALE(50)) u_c (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .solver_done(solver_done), .elapsed(elapsed_c), .live_count(live_c),
        .busy(busy_c), .valid(valid_c), .overflow(ovf_c));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [31:0] elapsed;
        logic        valid;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        int   t0, t1, t2, t3;
        int   exp_a, exp_b, exp_c;
        logic ovf_b;
    } vec_t;
    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_sb(input logic [31:0] e, input logic v);
        sb_t s;
        s.elapsed = e;
        s.valid   = v;
        sb_q.push_back(s);
    endtask

    // k=0 is the start edge T0; solver i rises at edge ti, completion at max(ti)
    task automatic run_vec(input int t0, input int t1, input int t2, input int t3);
        int tmax;
        tmax = t0;
        if (t1 > tmax) tmax = t1;
        if (t2 > tmax) tmax = t2;
        if (t3 > tmax) tmax = t3;
        for (int k = 0; k <= tmax; k++) begin
            start       = (k == 0);
            solver_done = {k >= t3, k >= t2, k >= t1, k >= t0};
            step();
        end
        start = 1'b0;
    endtask

    logic busy_prev = 1'b0;
    always @(negedge clk) begin
        if (busy_prev === 1'b1 && busy_a === 1'b0) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_end", 1, 0);
            end else begin
                sb_t s;
                s = sb_q.pop_front();
                chk("sb_elapsed", elapsed_a, s.elapsed);
                chk("sb_valid", valid_a, s.valid);
            end
        end
        busy_prev = busy_a;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{10, 25, 37, 40, 40, 40, 0, 1'b0};
        vecs[1] = '{5, 5, 5, 5, 5, 5, 0, 1'b0};
        vecs[2] = '{1, 1, 1, 1, 1, 1, 0, 1'b0};
        vecs[3] = '{120, 60, 3, 99, 120, 120, 2, 1'b0};
        vecs[4] = '{300, 10, 20, 30, 300, 255, 6, 1'b1};
        vecs[5] = '{50, 49, 1, 2, 50, 50, 1, 1'b0};
        vecs[6] = '{49, 2, 3, 4, 49, 49, 0, 1'b0};
        vecs[7] = '{1000, 1000, 1000, 1000, 1000, 255, 20, 1'b1};

        reset_n = 1'b0;
        step(); step();
        reset_n = 1'b1;
        step();
        chk("rst_busy", busy_a, 0);
        chk("rst_valid", valid_a, 0);
        chk("rst_elapsed", elapsed_a, 0);
        chk("rst_live", live_a, 0);
        chk("rst_ovf", ovf_a, 0);

        for (int v = 0; v < 8; v++) begin
            push_sb(vecs[v].exp_a, 1'b1);
            run_vec(vecs[v].t0, vecs[v].t1, vecs[v].t2, vecs[v].t3);
            chk("vec_busy_a", busy_a, 0);
            chk("vec_elapsed_b", elapsed_b, vecs[v].exp_b);
            chk("vec_ovf_b", ovf_b, vecs[v].ovf_b);
            chk("vec_elapsed_c", elapsed_c, vecs[v].exp_c);
            chk("vec_valid_c", valid_c, 1);
            solver_done = 4'b0;
            step();
        end

        // solver 0 high across start must fall and rise again
        solver_done = 4'b0001;
        step(); step();
        push_sb(20, 1'b1);
        for (int k = 0; k <= 20; k++) begin
            start          = (k == 0);
            solver_done[0] = (k < 5) || (k >= 20);
            solver_done[3:1] = (k >= 15) ? 3'b111 : 3'b000;
            step();
        end
        start = 1'b0;
        chk("hi_elapsed_b", elapsed_b, 20);
        chk("hi_elapsed_c", elapsed_c, 0);
        solver_done = 4'b0;
        step();

        // start on the final edge restarts instead of latching
        for (int k = 0; k <= 10; k++) begin
            start            = (k == 0) || (k == 10);
            solver_done[2:0] = (k >= 5) ? 3'b111 : 3'b000;
            solver_done[3]   = (k >= 10);
            step();
        end
        start = 1'b0;
        chk("coin_busy", busy_a, 1);
        chk("coin_live", live_a, 0);
        chk("coin_elapsed", elapsed_a, 20);
        step(); step(); step();
        chk("coin_live3", live_a, 3);
        push_sb(20, 1'b1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        solver_done = 4'b0;
        step();

        push_sb(40, 1'b1);
        run_vec(40, 40, 40, 40);
        solver_done = 4'b0;
        step();
        // abort five cycles into a run
        push_sb(40, 1'b1);
        for (int k = 0; k <= 5; k++) begin
            start = (k == 0);
            abort = (k == 5);
            step();
        end
        abort = 1'b0;
        chk("abort_busy", busy_a, 0);
        chk("abort_live", live_a, 0);
        chk("abort_elapsed", elapsed_a, 40);
        chk("abort_valid", valid_a, 1);
        chk("abort_live_c", live_c, 0);
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        chk("abst_busy_a", busy_a, 0);
        chk("abst_busy_c", busy_c, 0);
        step();
        chk("abst_busy_a2", busy_a, 0);

        // restart in RUN at 500, completion at 1000
        push_sb(500, 1'b1);
        for (int k = 0; k <= 1000; k++) begin
            start       = (k == 0) || (k == 500);
            solver_done = (k >= 1000) ? 4'b1111 : 4'b0000;
            step();
        end
        start = 1'b0;
        chk("rs_elapsed_c", elapsed_c, 10);
        chk("rs_elapsed_b", elapsed_b, 255);
        chk("rs_live_b", live_b, 255);
        chk("rs_ovf_b", ovf_b, 1);
        solver_done = 4'b0;
        step();

        // asynchronous reset mid-run
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (10) step();
        push_sb(0, 1'b0);
        reset_n = 1'b0;
        @(negedge clk);
        chk("mrst_busy", busy_a, 0);
        chk("mrst_valid", valid_a, 0);
        chk("mrst_elapsed", elapsed_a, 0);
        chk("mrst_live", live_a, 0);
        chk("mrst_ovf_b", ovf_b, 0);
        chk("mrst_elapsed_c", elapsed_c, 0);
        step();
        reset_n = 1'b1;
        step(); step();
        chk("sb_empty", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
